// File: rtl/rv32_dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package rv32_dmem_arbiter_pkg;

  localparam int RV_DMEM_AW = 12;
  localparam int RV_DATA_W  = 32;

  typedef logic [RV_DMEM_AW-1:0] rv_dmem_addr_t;
  typedef logic [RV_DATA_W-1:0]  rv32_data_t;
  typedef logic [3:0]            rv_dmem_be_t;

  localparam rv_dmem_be_t BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    RD_RSP,
    RMW_RD,
    RMW_WR
  } dmem_arb_state_e;

  typedef enum logic {
    REQ_IO,
    REQ_LSU
  } dmem_req_id_e;

endpackage

// File: rtl/rv32_dmem_arbiter_if.sv
// Request/response bundle for one data-memory requester (IO or LSU).
interface rv32_dmem_arbiter_if
  import rv32_dmem_arbiter_pkg::*;
#(
  parameter int AW = RV_DMEM_AW,
  parameter int DW = RV_DATA_W
) ();

  logic            req;
  logic            we;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] be;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  // Requester side drives the request fields and sees grant/response.
  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  // Arbiter side consumes the request fields and produces grant/response.
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);

endinterface

// File: rtl/rv32_be_merge.sv
// Combinational byte merge: each byte comes from new_data when its enable is set.
module rv32_be_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_data,
  input  logic [DATA_W-1:0]   new_data,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W / 8; gi++) begin : g_byte
      assign merged[gi*8 +: 8] = be[gi] ? new_data[gi*8 +: 8] : old_data[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/rv32_dmem_arbiter.sv
// Two-port arbiter in front of the single-port-pair data BRAM. Handles
// round-robin grants, program-mode lockout and partial writes via RMW.
module rv32_dmem_arbiter
  import rv32_dmem_arbiter_pkg::*;
#(
  parameter int DMEM_AW = RV_DMEM_AW,
  parameter int DATA_W  = RV_DATA_W
) (
  input  logic                rv32_io_clk,
  input  logic                rv32_io_rst,
  input  logic                rv32_io_program,
  rv32_dmem_arbiter_if.slave  io,
  rv32_dmem_arbiter_if.slave  lsu,
  output logic [DMEM_AW-1:0]  mem_raddr,
  output logic [DMEM_AW-1:0]  mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wen,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  dmem_arb_state_e     state_reg, state_next;
  dmem_req_id_e        last_win_reg, last_win_next;
  dmem_req_id_e        rd_owner_reg, rd_owner_next;
  logic [DMEM_AW-1:0]  rmw_addr_reg, rmw_addr_next;
  logic [DATA_W-1:0]   rmw_wdata_reg, rmw_wdata_next;
  logic [BE_W-1:0]     rmw_be_reg, rmw_be_next;

  logic                grant_ok;
  logic                win_lsu;
  logic                sel_we;
  logic [DMEM_AW-1:0]  sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;
  logic [DATA_W-1:0]   merged_data;

  // Old word arrives from the BRAM while the latched new bytes are held.
  rv32_be_merge #(.DATA_W(DATA_W)) u_be_merge (
    .old_data (mem_rdata),
    .new_data (rmw_wdata_reg),
    .be       (rmw_be_reg),
    .merged   (merged_data)
  );

  // Arbitration, response routing and the memory command for this cycle.
  always_comb begin
    state_next     = state_reg;
    last_win_next  = last_win_reg;
    rd_owner_next  = rd_owner_reg;
    rmw_addr_next  = rmw_addr_reg;
    rmw_wdata_next = rmw_wdata_reg;
    rmw_be_next    = rmw_be_reg;
    io.gnt         = 1'b0;
    lsu.gnt        = 1'b0;
    io.rvalid      = 1'b0;
    lsu.rvalid     = 1'b0;
    io.rdata       = '0;
    lsu.rdata      = '0;
    mem_raddr      = '0;
    mem_waddr      = '0;
    mem_wdata      = '0;
    mem_wen        = 1'b0;
    busy           = 1'b0;
    grant_ok       = 1'b0;
    // LSU wins when it is eligible and IO is absent or had the last grant.
    win_lsu        = lsu.req && !rv32_io_program && (!io.req || last_win_reg == REQ_IO);
    sel_we         = win_lsu ? lsu.we    : io.we;
    sel_addr       = win_lsu ? lsu.addr  : io.addr;
    sel_wdata      = win_lsu ? lsu.wdata : io.wdata;
    sel_be         = win_lsu ? lsu.be    : io.be;

    // Everything is held quiet while reset is asserted.
    if (!rv32_io_rst) begin
      case (state_reg)
        IDLE: begin
          grant_ok = 1'b1;
        end
        RD_RSP: begin
          grant_ok   = 1'b1;
          state_next = IDLE;
          if (rd_owner_reg == REQ_IO) begin
            io.rvalid = 1'b1;
            io.rdata  = mem_rdata;
          end else begin
            lsu.rvalid = 1'b1;
            lsu.rdata  = mem_rdata;
          end
        end
        RMW_RD: begin
          // Keep the address so the BRAM output still holds the old word next cycle.
          busy       = 1'b1;
          mem_raddr  = rmw_addr_reg;
          state_next = RMW_WR;
        end
        RMW_WR: begin
          busy       = 1'b1;
          mem_raddr  = rmw_addr_reg;
          mem_wen    = 1'b1;
          mem_waddr  = rmw_addr_reg;
          mem_wdata  = merged_data;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase

      if (grant_ok && (win_lsu || io.req)) begin
        io.gnt        = !win_lsu;
        lsu.gnt       = win_lsu;
        last_win_next = win_lsu ? REQ_LSU : REQ_IO;
        if (!sel_we) begin
          mem_raddr     = sel_addr;
          rd_owner_next = win_lsu ? REQ_LSU : REQ_IO;
          state_next    = RD_RSP;
        end else if (&sel_be) begin
          mem_wen    = 1'b1;
          mem_waddr  = sel_addr;
          mem_wdata  = sel_wdata;
          state_next = IDLE;
        end else if (sel_be == '0) begin
          state_next = IDLE;
        end else begin
          mem_raddr      = sel_addr;
          rmw_addr_next  = sel_addr;
          rmw_wdata_next = sel_wdata;
          rmw_be_next    = sel_be;
          state_next     = RMW_RD;
        end
      end
    end
  end

  // State, round-robin pointer, read owner and RMW latches.
  always_ff @(posedge rv32_io_clk) begin
    if (rv32_io_rst) begin
      state_reg     <= IDLE;
      last_win_reg  <= REQ_IO;
      rd_owner_reg  <= REQ_IO;
      rmw_addr_reg  <= '0;
      rmw_wdata_reg <= '0;
      rmw_be_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      last_win_reg  <= last_win_next;
      rd_owner_reg  <= rd_owner_next;
      rmw_addr_reg  <= rmw_addr_next;
      rmw_wdata_reg <= rmw_wdata_next;
      rmw_be_reg    <= rmw_be_next;
    end
  end

endmodule
